// File: rtl/rear_light_ctrl.sv
// Rear-light sequencer: synchronized button presses step the light mode,
// plus fast/slow blink square waves and an optional inactivity timeout.

module blink_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic blink
);
    localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [W-1:0] cnt;

    // Counter and output snap back to 0/1 at the same edge run drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (!run) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == W'(HALF - 1)) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

module rear_light_ctrl #(
    parameter int FAST_HALF = 2,
    parameter int SLOW_HALF = 8,
    parameter int TIMEOUT   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic [1:0] state,
    output logic       fast_blink,
    output logic       slow_blink,
    output logic       press
);
    typedef enum logic [1:0] {
        OFF    = 2'b00,
        ON     = 2'b01,
        FLASH1 = 2'b10,
        FLASH2 = 2'b11
    } mode_t;

    mode_t state_q, state_d;
    logic  s1, s2, prev;
    logic  timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= btn_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign press = s2 & ~prev;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int IW = $clog2(TIMEOUT + 1);
            logic [IW-1:0] idle_cnt;

            assign timeout_hit = (state_q != OFF) && !press &&
                                 (idle_cnt == IW'(TIMEOUT - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    idle_cnt <= '0;
                else if (press || state_q == OFF || timeout_hit)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + 1'b1;
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= OFF;
        else     state_q <= state_d;
    end

    // A press outranks a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        if (press) begin
            case (state_q)
                OFF:     state_d = ON;
                ON:      state_d = FLASH1;
                FLASH1:  state_d = FLASH2;
                default: state_d = OFF;
            endcase
        end else if (timeout_hit) begin
            state_d = OFF;
        end
    end

    assign state = state_q;

    // Blink runs only while staying in its mode, so entry and exit both
    // see the idle values at the state-change edge.
    blink_gen #(.HALF(FAST_HALF)) u_fast (
        .clk   (clk),
        .rst   (rst),
        .run   (state_q == FLASH1 && state_d == FLASH1),
        .blink (fast_blink)
    );

    blink_gen #(.HALF(SLOW_HALF)) u_slow (
        .clk   (clk),
        .rst   (rst),
        .run   (state_q == FLASH2 && state_d == FLASH2),
        .blink (slow_blink)
    );
endmodule

// File: tb/tb_rear_light_ctrl.sv
// Randomized + directed bench for rear_light_ctrl; a per-edge reference model
// feeds a scoreboard queue that a negedge monitor drains and compares.

module tb_rear_light_ctrl;
    localparam int FH = 2;
    localparam int SH = 8;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic [1:0] state;
    logic       fast_blink, slow_blink, press;

    rear_light_ctrl #(.FAST_HALF(FH), .SLOW_HALF(SH), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .state      (state),
        .fast_blink (fast_blink),
        .slow_blink (slow_blink),
        .press      (press)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       fb;
        logic       sb;
        logic       pr;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: mode, cycles spent in the mode, idle cycles since the
    // last press, and the last three sampled button levels.
    int m_mode, m_n, m_idle;
    bit m_hist[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    always @(posedge clk or posedge rst) begin : model
        bit   p;
        obs_t e;
        if (rst) begin
            m_mode = 0; m_n = 0; m_idle = 0;
            m_hist = '{0, 0, 0};
            exp_q.delete();
        end else begin
            p = m_hist[1] & ~m_hist[2];
            if (p) begin
                m_mode = (m_mode + 1) % 4; m_n = 0; m_idle = 0;
            end else if (m_mode != 0) begin
                m_idle++; m_n++;
                if (TO > 0 && m_idle == TO) begin
                    m_mode = 0; m_n = 0; m_idle = 0;
                end
            end else begin
                m_n++;
            end
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = btn_in;
            e.st = m_mode[1:0];
            e.fb = (m_mode == 2) ? (((m_n / FH) % 2) == 0) : 1'b1;
            e.sb = (m_mode == 3) ? (((m_n / SH) % 2) == 0) : 1'b1;
            e.pr = m_hist[1] & ~m_hist[2];
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        obs_t e, a;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, fast_blink, slow_blink, press};
            chk("scoreboard", int'(a), int'(e));
        end
    end

    // All stimulus changes land 2 time units after a falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic press_btn(input int hi, input int lo);
        btn_in = 1'b1;
        step(hi);
        btn_in = 1'b0;
        step(lo);
    endtask

    task automatic wait_mode(input int mode, input string name);
        int w = 0;
        while (m_mode != mode && w < 40) begin
            step(1);
            w++;
        end
        if (m_mode != mode) chk(name, m_mode, mode);
    endtask

    logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    int np;

    initial begin
        rst = 1'b1;
        btn_in = 1'b0;
        step(2);
        rst = 1'b0;
        chk("reset_state", int'({state, fast_blink, slow_blink, press}), 'b00110);

        for (int i = 0; i < 4; i++) begin
            press_btn(5, 5);
            chk("press_seq", int'(state), int'(seq[i]));
        end

        np = 0;
        btn_in = 1'b1;
        repeat (50) begin
            step(1);
            if (press) np++;
        end
        btn_in = 1'b0;
        step(5);
        chk("hold_single_press", np, 1);

        // Walk into FLASH1, then FLASH2, then reset while slow_blink is low.
        press_btn(1, 5);
        press_btn(1, 9);
        press_btn(1, 4);
        begin
            int w = 0;
            while (!(m_mode == 3 && ((m_n / SH) % 2) == 1) && w < 40) begin
                step(1);
                w++;
            end
        end
        chk("pre_reset_slow_low", int'(slow_blink), 0);
        #1 rst = 1'b1;
        #1 chk("async_reset", int'({state, fast_blink, slow_blink, press}), 'b00110);
        step(1);
        rst = 1'b0;
        step(5);
        chk("reset_hold", int'({state, fast_blink, slow_blink}), 'b0011);

        // Plain timeout: OFF exactly 20 cycles after entering ON.
        press_btn(1, 0);
        wait_mode(1, "enter_on");
        step(19);
        chk("timeout_before", int'(state), 1);
        step(1);
        chk("timeout_off", int'(state), 0);

        // Press landing on the timeout edge wins and restarts the counter.
        press_btn(1, 0);
        wait_mode(1, "enter_on2");
        step(17);
        btn_in = 1'b1;
        step(1);
        btn_in = 1'b0;
        step(2);
        chk("timeout_press_wins", int'(state), 2);
        step(19);
        chk("timeout_restart", int'(state), 2);
        step(1);
        chk("timeout_restart_off", int'(state), 0);

        repeat (300) begin
            press_btn($urandom_range(1, 8), $urandom_range(1, 30));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        end
        step(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/rear_light_ctrl.md
Name: rear_light_ctrl

Overview:
- Sequencer for the rear-light select mux.
- Debounced button presses step the 2-bit light mode: OFF → ON → FLASH1 → FLASH2 → OFF.
- Generates the fast_blink and slow_blink square waves that the mux consumes.
- An optional inactivity timeout returns the light to OFF.
- Sits between the board button and the mux: state, fast_blink and slow_blink drive the mux select and data inputs directly.

Parameters:
- FAST_HALF, 2, clock cycles per half-period of fast_blink (≥1).
- SLOW_HALF, 8, clock cycles per half-period of slow_blink (≥1, intended > FAST_HALF).
- TIMEOUT, 0, cycles without a press in any non-OFF state before forcing OFF; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_in  in  1  raw button level, asynchronous to clk.
- state  out  2  mode: 00 OFF, 01 ON, 10 FLASH1 (fast), 11 FLASH2 (slow). Registered.
- fast_blink  out  1  fast square wave. Registered.
- slow_blink  out  1  slow square wave. Registered.
- press  out  1  one-cycle pulse on each detected press. Debug/observe.

Behaviour:
- Reset (async assert, synchronous release behaviour on next clk edge):
  - state=00, fast_blink=1, slow_blink=1, press=0.
  - All counters 0, synchronizer and edge flops 0.
- Input conditioning:
  - 2-flop synchronizer s1→s2, then edge register prev.
  - press = s2 & ~prev.
  - btn_in high before clock edge E0 → press high in the cycle after edge E1 → state updates at edge E2 (3rd edge sampling btn high).
  - Holding btn_in high gives exactly one press.
  - Re-press requires btn_in low for ≥1 sampled edge.
  - Glitches shorter than one cycle may or may not be captured; no additional debounce is required.
- Mode FSM, advancing only on press:
  - OFF→ON, ON→FLASH1, FLASH1→FLASH2, FLASH2→OFF (wrap).
  - No press: hold state.
- Timeout (TIMEOUT>0):
  - Idle counter clears on press, on reset, and whenever state==OFF.
  - Otherwise it increments each cycle.
  - When the counter reaches TIMEOUT-1 with no press that cycle, state→OFF at that edge and the counter clears.
  - Press and timeout in the same cycle: press wins (normal advance), counter clears.
  - Counter width $clog2(TIMEOUT+1); never wraps.
  - With TIMEOUT=0, the idle counter is absent and tied to 0.
- Fast blink generator:
  - While state==FLASH1: counter counts 0..FAST_HALF-1. At FAST_HALF-1 the counter wraps to 0 and fast_blink toggles.
  - While state!=FLASH1: counter held 0, fast_blink held 1.
  - On entry to FLASH1 the output is therefore 1 for exactly FAST_HALF cycles, then alternates with period 2·FAST_HALF.
  - Leaving FLASH1 mid-period restores the held values at the same edge the state changes.
- Slow blink generator: identical rules with SLOW_HALF, gated by state==FLASH2.
- FAST_HALF=1 or SLOW_HALF=1: the output toggles every cycle while in its mode.
- Width rule: blink counters are $clog2(HALF) bits, minimum 1.
- No combinational path from btn_in to any output; all outputs are flop-driven.

Test Plan:
- Reset: assert rst mid-FLASH2 with slow_blink=0 → state=00, fast_blink=1, slow_blink=1 immediately (async), held until first press after release.
- Press sequence: four clean presses (btn high 5 cycles, low 5 cycles) → state 01, 10, 11, 00. Each change lands on the 3rd edge after btn is sampled high; press pulses exactly once per press.
- Hold: btn_in held high 50 cycles from OFF → single transition to 01, exactly one press pulse.
- Fast blink (FAST_HALF=2): enter FLASH1 → fast_blink pattern 1,1,0,0,1,1,0,0 starting the cycle state becomes 10. slow_blink stays 1 throughout.
- Slow blink (SLOW_HALF=8): enter FLASH2 → slow_blink 1 for 8 cycles, 0 for 8 cycles. On entry, fast_blink returns to 1 and its counter to 0.
- Timeout (TIMEOUT=20): enter ON, no press → state returns to 00 exactly 20 cycles after entry. Repeat with a press landing on the timeout cycle → state advances to 10, no OFF, counter restarts.
